// File: rtl/handshake_rr_share_arbiter.sv
// handshake_rr_share_arbiter
// Shares one downstream handshake consumer among NUM_INPUTS producers using a
// round-robin grant. The winning token is registered in a one-slot output
// buffer, so there is no combinational path from outs_valid/ins_valid to
// outs_valid, and the slot can drain and refill on the same edge.
// Optional feature: define HS_ARB_INDEX_EN to add the outs_index port, which
// reports the source channel of the buffered token.
module handshake_rr_share_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
  input  logic [NUM_INPUTS-1:0]            ins_valid,
  output logic [NUM_INPUTS-1:0]            ins_ready,
  output logic [DATA_WIDTH-1:0]            outs,
  output logic                             outs_valid,
`ifdef HS_ARB_INDEX_EN
  output logic [IDX_W-1:0]                 outs_index,
`endif
  input  logic                             outs_ready
);

  logic [DATA_WIDTH-1:0] outs_q, outs_d;
  logic                  outs_valid_q, outs_valid_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;

  logic                  grant_found;
  logic [IDX_W-1:0]      grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  can_load;
  logic                  take;
  int                    cand;

  // Round-robin search starting at ptr; the first valid channel wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    cand        = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
      if (!grant_found && ins_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant_data  = ins[cand*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Only the winner sees ready, and only when the slot can accept a token;
  // nothing is accepted while reset is asserted.
  always_comb begin
    can_load  = !outs_valid_q || outs_ready;
    take      = grant_found && can_load && !rst;
    ins_ready = '0;
    if (take) ins_ready[grant_idx] = 1'b1;
  end

  // Next slot contents and pointer: load on a transfer, otherwise drain or hold.
  always_comb begin
    outs_d       = outs_q;
    outs_valid_d = outs_valid_q;
    ptr_d        = ptr_q;
    if (take) begin
      outs_d       = grant_data;
      outs_valid_d = 1'b1;
      if (grant_idx == IDX_W'(NUM_INPUTS - 1)) ptr_d = '0;
      else                                     ptr_d = grant_idx + 1'b1;
    end else if (outs_valid_q && outs_ready) begin
      outs_valid_d = 1'b0;
    end
  end

  // Slot and pointer registers; reset discards any held token.
  always_ff @(posedge clk) begin
    if (rst) begin
      outs_q       <= '0;
      outs_valid_q <= 1'b0;
      ptr_q        <= '0;
    end else begin
      outs_q       <= outs_d;
      outs_valid_q <= outs_valid_d;
      ptr_q        <= ptr_d;
    end
  end

`ifdef HS_ARB_INDEX_EN
  logic [IDX_W-1:0] outs_index_q, outs_index_d;

  // Source index follows the payload: loaded on transfer, held otherwise.
  always_comb begin
    outs_index_d = outs_index_q;
    if (take) outs_index_d = grant_idx;
  end

  // Index register shares the slot's reset behaviour.
  always_ff @(posedge clk) begin
    if (rst) outs_index_q <= '0;
    else     outs_index_q <= outs_index_d;
  end

  assign outs_index = outs_index_q;
`endif

  assign outs       = outs_q;
  assign outs_valid = outs_valid_q;

endmodule
